// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the two-requester burst arbiter in front of a FIFO enq port.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int ARB_REQS = 2;

   // Word counter width; a 2-word burst still needs one bit.
   function automatic int cnt_width(input int burst_len);
      return (burst_len <= 2) ? 1 : $clog2(burst_len);
   endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational 2-way round-robin select: a lone requester wins, a tie goes to ~last.
module fifo_arb_rr_pick
   import fifo_arb_pkg::*;
(
   input  logic [ARB_REQS-1:0] valid,
   input  logic                last,
   output logic                pick,
   output logic                any
);

   always_comb begin
      any  = |valid;
      pick = (valid[1] & valid[0]) ? ~last : valid[1];
   end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Grants one FIFO write port to two requesters in fixed-length round-robin bursts.
// Optional FIFO_ARB_STATS_EN adds per-requester completed-burst counters.
//
//   state | meaning
//   IDLE  | no owner, all readies low; arbitrates on any valid
//   BURST | owner passes through to the FIFO until BURST_LEN words are written
module fifo_burst_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_in_0_valid,
   output logic                  io_in_0_ready,
   input  logic [DATA_WIDTH-1:0] io_in_0_bits,
   input  logic                  io_in_1_valid,
   output logic                  io_in_1_ready,
   input  logic [DATA_WIDTH-1:0] io_in_1_bits,
   output logic                  io_out_valid,
   input  logic                  io_out_ready,
   output logic [DATA_WIDTH-1:0] io_out_bits,
   output logic [ARB_REQS-1:0]   io_grant,
   output logic                  io_busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [15:0]           io_bursts_0,
   output logic [15:0]           io_bursts_1
`endif
);

   localparam int             CW       = cnt_width(BURST_LEN);
   localparam logic [CW-1:0]  CNT_LAST = CW'(BURST_LEN - 1);

   arb_state_t          state;
   logic                owner;
   logic                last;
   logic [CW-1:0]       count;
   logic [ARB_REQS-1:0] in_valid;
   logic                pick;
   logic                any;
   logic                owner_valid;
   logic                xfer;
   logic                burst_done;

   assign in_valid = {io_in_1_valid, io_in_0_valid};

   fifo_arb_rr_pick u_rr_pick (
      .valid (in_valid),
      .last  (last),
      .pick  (pick),
      .any   (any)
   );

   // Bits always follow the owner mux so the FIFO never sees X, even when invalid.
   always_comb begin
      owner_valid   = owner ? io_in_1_valid : io_in_0_valid;
      io_out_bits   = owner ? io_in_1_bits : io_in_0_bits;
      io_busy       = (state == BURST);
      io_out_valid  = io_busy & owner_valid;
      io_in_0_ready = io_busy & ~owner & io_out_ready;
      io_in_1_ready = io_busy & owner & io_out_ready;
      io_grant      = io_busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
      xfer          = io_busy & owner_valid & io_out_ready;
      burst_done    = xfer & (count == CNT_LAST);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  owner <= pick;
                  count <= '0;
                  state <= BURST;
               end
            end
            BURST: begin
               if (burst_done) begin
                  state <= IDLE;
                  last  <= owner;
                  count <= '0;
               end else if (xfer) begin
                  count <= count + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         io_bursts_0 <= '0;
         io_bursts_1 <= '0;
      end else if (burst_done) begin
         if (owner) io_bursts_1 <= io_bursts_1 + 16'd1;
         else       io_bursts_0 <= io_bursts_0 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Scoreboard bench for fifo_burst_arbiter: directed bursts, stalls, owner drop-out and reset.
module tb_fifo_burst_arbiter;

   localparam int DW = 64;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          io_in_0_valid = 1'b0;
   logic          io_in_0_ready;
   logic [DW-1:0] io_in_0_bits = '0;
   logic          io_in_1_valid = 1'b0;
   logic          io_in_1_ready;
   logic [DW-1:0] io_in_1_bits = '0;
   logic          io_out_valid;
   logic          io_out_ready = 1'b0;
   logic [DW-1:0] io_out_bits;
   logic [1:0]    io_grant;
   logic          io_busy;
`ifdef FIFO_ARB_STATS_EN
   logic [15:0]   io_bursts_0;
   logic [15:0]   io_bursts_1;
`endif

   fifo_burst_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .io_in_0_valid (io_in_0_valid),
      .io_in_0_ready (io_in_0_ready),
      .io_in_0_bits  (io_in_0_bits),
      .io_in_1_valid (io_in_1_valid),
      .io_in_1_ready (io_in_1_ready),
      .io_in_1_bits  (io_in_1_bits),
      .io_out_valid  (io_out_valid),
      .io_out_ready  (io_out_ready),
      .io_out_bits   (io_out_bits),
      .io_grant      (io_grant),
      .io_busy       (io_busy)
`ifdef FIFO_ARB_STATS_EN
      ,
      .io_bursts_0   (io_bursts_0),
      .io_bursts_1   (io_bursts_1)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]    grant;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   bit            en0 = 1'b1;
   bit            en1 = 1'b1;
   bit            rdy = 1'b1;
   bit            rst = 1'b1;
   int            n_chk = 0;
   int            n_fail = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endfunction

   function automatic logic [DW-1:0] word(int req, int tst, int i);
      return {(req != 0) ? 16'hB1B1 : 16'hA0A0, 32'h0, 8'(tst), 8'(i)};
   endfunction

   task automatic load(int req, int tst, int n);
      for (int i = 0; i < n; i++) begin
         if (req != 0) q1.push_back(word(1, tst, i));
         else          q0.push_back(word(0, tst, i));
      end
   endtask

   task automatic expect_words(int req, int tst, int first, int n);
      exp_t e;
      for (int i = first; i < first + n; i++) begin
         e.grant = (req != 0) ? 2'b10 : 2'b01;
         e.data  = word(req, tst, i);
         exp_q.push_back(e);
      end
   endtask

   // One cycle: drive at negedge, settle, then retire any word the DUT accepted.
   task automatic step();
      @(negedge clock);
      reset         = rst;
      io_in_0_valid = en0 && (q0.size() > 0) && !rst;
      io_in_0_bits  = (q0.size() > 0) ? q0[0] : '0;
      io_in_1_valid = en1 && (q1.size() > 0) && !rst;
      io_in_1_bits  = (q1.size() > 0) ? q1[0] : '0;
      io_out_ready  = rdy;
      #1;
      if (io_in_0_valid && io_in_0_ready) void'(q0.pop_front());
      if (io_in_1_valid && io_in_1_ready) void'(q1.pop_front());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (io_out_valid && io_out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_word: got %0h expected none", io_out_bits);
            end else begin
               e = exp_q.pop_front();
               chk("out_bits", io_out_bits, e.data);
               chk("out_grant", {62'd0, io_grant}, {62'd0, e.grant});
            end
         end
      end
   end

   initial begin : stimulus
      // 1: lone requester 0, reset state, 4 back-to-back words
      do_reset();
      chk("rst_grant", {62'd0, io_grant}, 64'd0);
      chk("rst_busy", {63'd0, io_busy}, 64'd0);
      chk("rst_out_valid", {63'd0, io_out_valid}, 64'd0);
      load(0, 1, 4);
      expect_words(0, 1, 0, 4);
      step();
      chk("t1_idle_grant", {62'd0, io_grant}, 64'd0);
      chk("t1_idle_ready", {63'd0, io_in_0_ready}, 64'd0);
      chk("t1_idle_valid", {63'd0, io_out_valid}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t1_grant", {62'd0, io_grant}, 64'd1);
         chk("t1_ready0", {63'd0, io_in_0_ready}, 64'd1);
      end
      step();
      chk("t1_end_busy", {63'd0, io_busy}, 64'd0);
      chk("t1_drained", 64'(q0.size()), 64'd0);

      // 2: both requesters continuous -> 0,1,0,1 with a bubble between bursts
      do_reset();
      load(0, 2, 8);
      load(1, 2, 8);
      expect_words(0, 2, 0, 4);
      expect_words(1, 2, 0, 4);
      expect_words(0, 2, 4, 4);
      expect_words(1, 2, 4, 4);
      for (int c = 0; c < 20; c++) begin
         step();
         chk("t2_excl", {63'd0, io_in_0_ready & io_in_1_ready}, 64'd0);
         if (c % 5 == 0) chk("t2_bubble", {62'd0, io_grant}, 64'd0);
         else            chk("t2_grant", {62'd0, io_grant}, ((c / 5) % 2 != 0) ? 64'd2 : 64'd1);
      end
      chk("t2_drained", 64'(q0.size() + q1.size()), 64'd0);

      // 3: FIFO full for 5 cycles after word 2
      do_reset();
      load(0, 3, 4);
      expect_words(0, 3, 0, 4);
      step();
      step();
      step();
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_stall_ready", {63'd0, io_in_0_ready}, 64'd0);
         chk("t3_stall_grant", {62'd0, io_grant}, 64'd1);
         chk("t3_stall_valid", {63'd0, io_out_valid}, 64'd1);
      end
      rdy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t3_resume_ready", {63'd0, io_in_0_ready}, 64'd1);
      end
      step();
      chk("t3_end_busy", {63'd0, io_busy}, 64'd0);
      chk("t3_drained", 64'(q0.size()), 64'd0);

      // 4: owner drops valid mid-burst, no preemption by requester 1
      do_reset();
      load(0, 4, 4);
      load(1, 4, 4);
      expect_words(0, 4, 0, 4);
      expect_words(1, 4, 0, 4);
      step();
      step();
      en0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_hold_grant", {62'd0, io_grant}, 64'd1);
         chk("t4_hold_ready1", {63'd0, io_in_1_ready}, 64'd0);
         chk("t4_hold_valid", {63'd0, io_out_valid}, 64'd0);
      end
      en0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_finish_grant", {62'd0, io_grant}, 64'd1);
      end
      step();
      chk("t4_bubble", {62'd0, io_grant}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t4_r1_grant", {62'd0, io_grant}, 64'd2);
      end
      step();
      chk("t4_drained", 64'(q0.size() + q1.size()), 64'd0);

      // 5: reset during word 2 abandons the burst; requester 0 wins the retie
      do_reset();
      load(0, 5, 6);
      load(1, 5, 4);
      expect_words(0, 5, 0, 6);
      expect_words(1, 5, 0, 4);
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("t5_post_rst_grant", {62'd0, io_grant}, 64'd0);
      chk("t5_post_rst_busy", {63'd0, io_busy}, 64'd0);
      step();
      chk("t5_rewin_grant", {62'd0, io_grant}, 64'd1);
      for (int i = 0; i < 3; i++) step();
      step();
      chk("t5_bubble", {62'd0, io_grant}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t5_r1_grant", {62'd0, io_grant}, 64'd2);
      end
      step();
      chk("t5_drained", 64'(q0.size() + q1.size()), 64'd0);

`ifdef FIFO_ARB_STATS_EN
      // 6: burst statistics, 3 bursts from requester 0 and 2 from requester 1
      do_reset();
      chk("t6_rst_bursts0", {48'd0, io_bursts_0}, 64'd0);
      chk("t6_rst_bursts1", {48'd0, io_bursts_1}, 64'd0);
      load(0, 6, 12);
      load(1, 6, 8);
      expect_words(0, 6, 0, 4);
      expect_words(1, 6, 0, 4);
      expect_words(0, 6, 4, 4);
      expect_words(1, 6, 4, 4);
      expect_words(0, 6, 8, 4);
      for (int i = 0; i < 26; i++) step();
      chk("t6_bursts0", {48'd0, io_bursts_0}, 64'd3);
      chk("t6_bursts1", {48'd0, io_bursts_1}, 64'd2);
`endif

      step();
      step();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
